// File: rtl/enemy_draw_pkg.sv
// Shared types and screen constants for the sprite drawers (enemy and self).
package enemy_draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan counter over a SIZE x SIZE sprite; shared by the enemy and self drawers.
module sprite_scan_counter #(
    parameter int SIZE = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_en,
    output logic [$clog2(SIZE)-1:0]   o_col,
    output logic [$clog2(SIZE)-1:0]   o_row,
    output logic                      o_last
);

    localparam int LW = $clog2(SIZE);

    logic [2*LW-1:0] r_k;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_k <= '0;
        end else if (i_en) begin
            r_k <= r_k + 1'b1;
        end
    end

    // SIZE is a power of two, so col/row are just the low/high halves of k.
    assign o_col  = r_k[LW-1:0];
    assign o_row  = r_k[2*LW-1:LW];
    assign o_last = &r_k;

endmodule

// File: rtl/enemy_draw.sv
// Enemy sprite mover: erases the square at its old position, then draws it at the new one.
module enemy_draw
    import enemy_draw_pkg::*;
#(
    parameter int         SIZE        = 4,
    parameter int         X_MAX       = SCREEN_W - 1,
    parameter int         Y_MAX       = SCREEN_H - 1,
    parameter logic [2:0] ERASE_COLOR = BLACK
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_go,
    input  logic [7:0] i_x_in,
    input  logic [7:0] i_y_in,
    input  logic [2:0] i_color_in,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_color,
    output logic       o_plot,
    output logic       o_busy,
    output logic       o_done
);

    localparam int LW = $clog2(SIZE);

    draw_state_t r_state;
    draw_state_t w_state_next;

    logic [7:0] r_old_x;
    logic [7:0] r_old_y;
    logic [7:0] r_new_x;
    logic [7:0] r_new_y;
    logic [2:0] r_new_c;
    logic       r_old_valid;

    logic [LW-1:0] w_col;
    logic [LW-1:0] w_row;
    logic          w_last;
    logic          w_k_clear;
    logic          w_k_en;

    logic [7:0] w_base_x;
    logic [7:0] w_base_y;
    logic [8:0] w_x_sum;
    logic [8:0] w_y_sum;

    // k restarts on entry to each sweep; the ERASE->DRAW handoff clears it explicitly.
    assign w_k_clear = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                       ((r_state == ST_ERASE) && w_last);
    assign w_k_en    = (r_state == ST_ERASE) || (r_state == ST_DRAW);

    sprite_scan_counter #(
        .SIZE (SIZE)
    ) u_scan (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_k_clear),
        .i_en    (w_k_en),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_old_x     <= '0;
            r_old_y     <= '0;
            r_new_x     <= '0;
            r_new_y     <= '0;
            r_new_c     <= '0;
            r_old_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && i_go) begin
                r_new_x <= i_x_in;
                r_new_y <= i_y_in;
                r_new_c <= i_color_in;
            end
            if (r_state == ST_DONE) begin
                r_old_x     <= r_new_x;
                r_old_y     <= r_new_y;
                r_old_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_go) begin
                    w_state_next = r_old_valid ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                if (w_last) begin
                    w_state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_base_x = (r_state == ST_ERASE) ? r_old_x : r_new_x;
    assign w_base_y = (r_state == ST_ERASE) ? r_old_y : r_new_y;
    // Nine-bit sums so a sprite hanging off the right/bottom edge is clipped, not wrapped.
    assign w_x_sum  = {1'b0, w_base_x} + 9'(w_col);
    assign w_y_sum  = {1'b0, w_base_y} + 9'(w_row);

    always_comb begin
        o_x     = '0;
        o_y     = '0;
        o_color = '0;
        o_plot  = 1'b0;
        if ((r_state == ST_ERASE) || (r_state == ST_DRAW)) begin
            o_x     = w_x_sum[7:0];
            o_y     = w_y_sum[7:0];
            o_color = (r_state == ST_ERASE) ? ERASE_COLOR : r_new_c;
            o_plot  = (w_x_sum <= 9'(X_MAX)) && (w_y_sum <= 9'(Y_MAX));
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_enemy_draw.sv
// Directed bench for enemy_draw: draw, erase+redraw, clipping, go-while-busy, reset mid-sweep.
module tb_enemy_draw;

    logic       clk;
    logic       reset;
    logic       go;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [2:0] color_in;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    enemy_draw dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_go       (go),
        .i_x_in     (x_in),
        .i_y_in     (y_in),
        .i_color_in (color_in),
        .o_x        (x),
        .o_y        (y),
        .o_color    (color),
        .o_plot     (plot),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy);
        check({tag, " x"},     32'(x),     32'd0);
        check({tag, " y"},     32'(y),     32'd0);
        check({tag, " color"}, 32'(color), 32'd0);
        check({tag, " plot"},  32'(plot),  32'd0);
        check({tag, " busy"},  32'(busy),  32'(exp_busy));
    endtask

    // Launch a move: go high across one rising edge, then back low in cycle 1.
    task automatic start_move(input int mx, input int my, input logic [2:0] mc);
        go       = 1'b1;
        x_in     = 8'(mx);
        y_in     = 8'(my);
        color_in = mc;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Check n pixels of a 4x4 sweep; optionally pulse go with (50,50) at pixel index inj.
    task automatic sweep(input string tag, input int bx, input int by, input logic [2:0] c,
                         input int n, input int inj, output int nplot);
        int px, py;
        logic ep;
        nplot = 0;
        for (int i = 0; i < n; i++) begin
            go = 1'b0;
            px = bx + (i % 4);
            py = by + (i / 4);
            ep = (px <= 159) && (py <= 119);
            check($sformatf("%s px%0d x", tag, i),     32'(x),     32'(px & 255));
            check($sformatf("%s px%0d y", tag, i),     32'(y),     32'(py & 255));
            check($sformatf("%s px%0d color", tag, i), 32'(color), 32'(c));
            check($sformatf("%s px%0d plot", tag, i),  32'(plot),  32'(ep));
            check($sformatf("%s px%0d busy", tag, i),  32'(busy),  32'd1);
            check($sformatf("%s px%0d done", tag, i),  32'(done),  32'd0);
            if (plot === 1'b1) nplot++;
            if (i == inj) begin
                go       = 1'b1;
                x_in     = 8'd50;
                y_in     = 8'd50;
                color_in = 3'b001;
            end
            @(negedge clk);
        end
        go = 1'b0;
    endtask

    // At the DONE cycle: one-cycle done pulse, then back to IDLE.
    task automatic expect_done(input string tag);
        check({tag, " done"}, 32'(done), 32'd1);
        check_quiet({tag, " in-done"}, 1'b1);
        @(negedge clk);
        check({tag, " done-drop"}, 32'(done), 32'd0);
        check_quiet({tag, " idle"}, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    int np;

    initial begin
        reset    = 1'b1;
        go       = 1'b0;
        x_in     = '0;
        y_in     = '0;
        color_in = '0;

        // Reset state
        do_reset();
        check("reset done", 32'(done), 32'd0);
        check_quiet("reset", 1'b0);

        // First move after reset: draw only
        start_move(10, 20, 3'b100);
        sweep("m1 draw", 10, 20, 3'b100, 16, -1, np);
        expect_done("m1");

        // Second move: erase old, draw new
        start_move(11, 20, 3'b010);
        sweep("m2 erase", 10, 20, 3'b000, 16, -1, np);
        sweep("m2 draw", 11, 20, 3'b010, 16, -1, np);
        expect_done("m2");

        // Clipping at the bottom-right corner
        do_reset();
        start_move(158, 118, 3'b111);
        sweep("clip draw", 158, 118, 3'b111, 16, -1, np);
        check("clip plot count", 32'(np), 32'd4);
        expect_done("clip");

        // go pulsed during DRAW pixel 5 is ignored
        start_move(30, 40, 3'b101);
        sweep("busy erase", 158, 118, 3'b000, 16, -1, np);
        sweep("busy draw", 30, 40, 3'b101, 16, 4, np);
        expect_done("busy");
        start_move(60, 60, 3'b011);
        sweep("after erase", 30, 40, 3'b000, 16, -1, np);
        sweep("after draw", 60, 60, 3'b011, 16, -1, np);
        expect_done("after");

        // Reset during DRAW cycle 8
        do_reset();
        start_move(70, 70, 3'b110);
        sweep("rst draw", 70, 70, 3'b110, 7, -1, np);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst-mid done", 32'(done), 32'd0);
        check_quiet("rst-mid", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst-idle%0d done", i), 32'(done), 32'd0);
            check($sformatf("rst-idle%0d busy", i), 32'(busy), 32'd0);
        end
        start_move(80, 90, 3'b001);
        sweep("rst next draw", 80, 90, 3'b001, 16, -1, np);
        expect_done("rst next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_draw.md
# enemy_draw

Sequential pixel generator that erases a square sprite at its previous position and redraws it at a new position, emitting one pixel per clock. It sits directly upstream of the self/enemy datapath select mux and drives the enemy-side x/y/color inputs; the control FSM pulses `go` whenever the enemy moves and waits for `done` before switching the mux or issuing the next move.

## Interface
- `SIZE`, 4, sprite edge length in pixels; power of two, 2..16.
- `X_MAX`, 159, last visible column.
- `Y_MAX`, 119, last visible row.
- `ERASE_COLOR`, 3'b000, background color used for erase pixels.

- `clk` in 1 system clock; the only clock.
- `reset` in 1 synchronous, active-high reset.
- `go` in 1 start request, sampled only in IDLE.
- `x_in` in 8 new sprite top-left column.
- `y_in` in 8 new sprite top-left row.
- `color_in` in 3 new sprite color.
- `x` out 8 current pixel column.
- `y` out 8 current pixel row.
- `color` out 3 current pixel color.
- `plot` out 1 pixel write enable for the VGA adapter.
- `busy` out 1 high in every non-IDLE state.
- `done` out 1 one-cycle pulse at the end of a move.

## Operation
- States:
  - IDLE: wait for `go`.
  - ERASE: sweep the old position.
  - DRAW: sweep the new position.
  - DONE: one cycle.
- Internal regs: `old_x`, `old_y` (8b), `new_x`, `new_y` (8b), `new_c` (3b), `old_valid` (1b), scan counter `k` (2·log2(SIZE) bits).
- IDLE with `go`=1:
  - Capture `x_in`/`y_in`/`color_in` into `new_*`.
  - Clear `k`.
  - Go to ERASE if `old_valid`=1, else straight to DRAW.
- Pixel mapping is row-major:
  - col = `k` mod SIZE; row = `k` / SIZE.
  - Pixel x = base_x + col; pixel y = base_y + row.
  - Sums are computed 9 bits wide; `x`/`y` output the low 8 bits.
- ERASE:
  - base = `old_*`; `color`=ERASE_COLOR.
  - After `k`=SIZE²−1, clear `k` and go to DRAW.
- DRAW:
  - base = `new_*`; `color`=`new_c`.
  - After `k`=SIZE²−1, go to DONE.
- DONE:
  - `done`=1.
  - `old_x`←`new_x`, `old_y`←`new_y`, `old_valid`←1.
  - Return to IDLE.
- Clipping:
  - In ERASE/DRAW, `plot`=1 only if the 9-bit x sum ≤ X_MAX and the 9-bit y sum ≤ Y_MAX; otherwise `plot`=0.
  - A clipped pixel still consumes its cycle; sweep length never changes.
- `go` is ignored in ERASE, DRAW and DONE (not queued).
- Outputs are Moore, decoded from state, `k` and the base regs.
- In IDLE and DONE: `x`=0, `y`=0, `color`=0, `plot`=0.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - state=IDLE, `k`=0, `old_valid`=0, all position/color regs 0.
  - All outputs 0.
- Reset mid-operation:
  - Abort immediately; no `done` is issued.
  - The next move skips erase, because `old_valid`=0.
- With `go` sampled high at edge 0:
  - With erase: ERASE pixels in cycles 1..SIZE², DRAW in SIZE²+1..2·SIZE², `done` in cycle 2·SIZE²+1. For SIZE=4: erase 1–16, draw 17–32, done 33.
  - First move after reset: DRAW in 1..SIZE², `done` in SIZE²+1 (cycle 17 for SIZE=4).
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
  - The earliest next `go` accepted is at the edge ending the first IDLE cycle after DONE.
- `go` held high continuously: one move per IDLE visit; the new position is re-captured each time.

## Structure
- Shared package holds:
  - the state enum (IDLE, ERASE, DRAW, DONE);
  - screen constants SCREEN_W=160 and SCREEN_H=120, from which X_MAX/Y_MAX defaults are derived;
  - the 3-bit color constants, including BLACK.
- One sub-module is natural: `sprite_scan_counter`.
  - Inputs: clear, enable.
  - Outputs: col, row, and a last flag (`k`=SIZE²−1).
  - It is reused for the self-sprite drawer.

## Test plan
- Reset check: assert `reset` for 2 cycles, then release → all outputs 0, `busy`=0; `go` pulse with (10,20,3'b100) → cycles 1–16 plot x=10..13 and y=20..23 row-major with color 3'b100; `done` in cycle 17; no erase pixels.
- Second move after the first: `go` with (11,20,3'b010) → cycles 1–16 plot old square (10..13,20..23) with color 000; cycles 17–32 plot new square (11..14,20..23) with color 3'b010; `done` in cycle 33, for exactly one cycle.
- Clipping: after reset, `go` with (158,118,3'b111) → only (158,118), (159,118), (158,119), (159,119) have `plot`=1; `done` still in cycle 17.
- `go` while busy: pulse `go` with (50,50) during DRAW cycle 5 → sweep is unchanged; the following move erases the originally captured position, not (50,50).
- Reset mid-DRAW (cycle 8) → next cycle all outputs 0, `busy`=0, no `done`; next `go` draws without an erase phase, `done` at cycle 17.
